// File: rtl/hssaer_evt_asm_pkg.sv
// Shared types and defaults for the HSSAER event assembler.
package hssaer_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int NCHUNK_DEF = 4;
  localparam int TO_MAX_DEF = 64;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

endpackage

// File: rtl/hssaer_fifo2.sv
// Two-entry first-in first-out buffer; entry 0 is always the head.
module hssaer_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         do_pop;
  logic         do_push;

  assign dout  = e0_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

  // Next occupancy and contents; a push into a full buffer only lands when a pop frees the head.
  always_comb begin
    cnt_d   = cnt_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = din;
        else               e1_d = din;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = din;
        end else begin
          e0_d = e1_q;
          e1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage registers, cleared so the output word reads zero out of reset.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

endmodule

// File: rtl/hssaer_evt_asm.sv
// Assembles NCHUNK decoded HSSAER chunks into one event word, with
// parity/truncation/overflow statistics and a two-entry output buffer.
module hssaer_evt_asm
  import hssaer_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int NCHUNK = NCHUNK_DEF,
  parameter int TO_MAX = TO_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    _rst,
  input  logic [DSIZE-1:0]        in_d,
  input  logic                    in_st,
  input  logic                    in_dok,
  input  logic                    in_err,
  input  logic                    in_idle,
  output logic [DSIZE*NCHUNK-1:0] evt_data,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_par,
  output logic [CNT_W-1:0]        cnt_trunc,
  output logic [CNT_W-1:0]        cnt_ovf,
  output logic                    busy
);

  localparam int WW = DSIZE * NCHUNK;
  localparam int IW = $clog2(NCHUNK + 1);
  localparam int TW = $clog2(TO_MAX + 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [WW-1:0]  word_q, word_d;
  logic           busy_q, busy_d;
  logic [CNT_W-1:0] cnt_par_q, cnt_par_d;
  logic [CNT_W-1:0] cnt_trunc_q, cnt_trunc_d;
  logic [CNT_W-1:0] cnt_ovf_q, cnt_ovf_d;

  logic [WW-1:0]  chunk_word;
  logic           push;
  logic           pop;
  logic           par_inc;
  logic           trunc_inc;
  logic           ovf_inc;
  logic           fifo_full;
  logic           fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // New chunk shifted in below the chunks already collected.
  assign chunk_word = {word_q[WW-DSIZE-1:0], in_d};

  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign ovf_inc   = push && fifo_full && !pop;
  assign busy      = busy_q;
  assign cnt_par   = cnt_par_q;
  assign cnt_trunc = cnt_trunc_q;
  assign cnt_ovf   = cnt_ovf_q;

  // Frame sequencing: error beats idle beats strobe; a quiet gap of TO_MAX cycles truncates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    word_d    = word_q;
    push      = 1'b0;
    par_inc   = 1'b0;
    trunc_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_st && !in_err) begin
          word_d  = {{(WW-DSIZE){1'b0}}, in_d};
          idx_d   = IW'(1);
          tmr_d   = '0;
          state_d = in_dok ? ST_COLLECT : ST_DROP;
        end
      end
      ST_COLLECT, ST_DROP: begin
        if (in_err || in_idle) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          tmr_d     = '0;
          trunc_inc = 1'b1;
        end else if (in_st) begin
          tmr_d = '0;
          if (idx_q == IW'(NCHUNK - 1)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            if (state_q == ST_COLLECT && in_dok) push    = 1'b1;
            else                                 par_inc = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
            if (state_q == ST_COLLECT && in_dok) word_d  = chunk_word;
            else                                 state_d = ST_DROP;
          end
        end else if (tmr_q == TW'(TO_MAX - 1)) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          tmr_d     = '0;
          trunc_inc = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        tmr_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Statistics counters: saturating, with clear taking precedence over any increment.
  always_comb begin
    cnt_par_d   = cnt_clr ? '0 : sat_inc(cnt_par_q, par_inc);
    cnt_trunc_d = cnt_clr ? '0 : sat_inc(cnt_trunc_q, trunc_inc);
    cnt_ovf_d   = cnt_clr ? '0 : sat_inc(cnt_ovf_q, ovf_inc);
  end

  // FSM, assembly and counter registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      cnt_par_q   <= '0;
      cnt_trunc_q <= '0;
      cnt_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      cnt_par_q   <= cnt_par_d;
      cnt_trunc_q <= cnt_trunc_d;
      cnt_ovf_q   <= cnt_ovf_d;
    end
  end

  hssaer_fifo2 #(
    .W (WW)
  ) u_fifo (
    .clk   (clk),
    ._rst  (_rst),
    .push  (push),
    .din   (chunk_word),
    .pop   (pop),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_hssaer_evt_asm.sv
// Bench for hssaer_evt_asm: directed scenarios plus a randomized run,
// all checked against a frame-level reference model.
module tb_hssaer_evt_asm;

  localparam int DSIZE  = 8;
  localparam int NCHUNK = 4;
  localparam int TO_MAX = 64;
  localparam int WW     = DSIZE * NCHUNK;

  logic          clk = 1'b0;
  logic          _rst;
  logic [7:0]    in_d;
  logic          in_st, in_dok, in_err, in_idle;
  logic [WW-1:0] evt_data;
  logic          evt_valid, evt_ready, cnt_clr;
  logic [15:0]   cnt_par, cnt_trunc, cnt_ovf;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: chunks of the current frame, output queue, counters.
  logic [7:0]    m_ch[$];
  logic [WW-1:0] m_q[$];
  bit            m_frame;
  bit            m_bad;
  int            m_quiet;
  int            m_par, m_trunc, m_ovf;
  bit            rdy_now;

  always #5 clk = ~clk;

  hssaer_evt_asm #(.DSIZE(DSIZE), .NCHUNK(NCHUNK), .TO_MAX(TO_MAX)) dut (
    .clk(clk), ._rst(_rst), .in_d(in_d), .in_st(in_st), .in_dok(in_dok),
    .in_err(in_err), .in_idle(in_idle), .evt_data(evt_data), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .cnt_clr(cnt_clr), .cnt_par(cnt_par), .cnt_trunc(cnt_trunc),
    .cnt_ovf(cnt_ovf), .busy(busy)
  );

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_ch.delete(); m_q.delete();
    m_frame = 0; m_bad = 0; m_quiet = 0;
    m_par = 0; m_trunc = 0; m_ovf = 0;
  endtask

  task automatic model_abort();
    m_ch.delete();
    m_frame = 0;
    m_trunc = sat16(m_trunc + 1);
  endtask

  // One clock cycle: drive inputs, advance the model, sample just after the edge.
  task automatic step(input bit st, input logic [7:0] d, input bit dok, input bit err,
                      input bit idle, input bit rdy, input bit clr);
    logic [WW-1:0] w;
    bit pop;
    @(negedge clk);
    in_st = st; in_d = d; in_dok = dok; in_err = err; in_idle = idle;
    evt_ready = rdy; cnt_clr = clr;
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (!m_frame) begin
      if (st && !err) begin
        m_ch.delete(); m_ch.push_back(d);
        m_frame = 1; m_bad = !dok; m_quiet = 0;
      end
    end else if (err || idle) begin
      model_abort();
    end else if (st) begin
      m_ch.push_back(d);
      m_bad = m_bad || !dok;
      m_quiet = 0;
      if (m_ch.size() == NCHUNK) begin
        m_frame = 0;
        if (m_bad) begin
          m_par = sat16(m_par + 1);
        end else begin
          w = '0;
          foreach (m_ch[i]) w = (w << DSIZE) | WW'(m_ch[i]);
          if (m_q.size() < 2) m_q.push_back(w);
          else m_ovf = sat16(m_ovf + 1);
        end
        m_ch.delete();
      end
    end else begin
      m_quiet++;
      if (m_quiet >= TO_MAX) model_abort();
    end
    if (clr) begin m_par = 0; m_trunc = 0; m_ovf = 0; end
    @(posedge clk); #1;
    in_st = 0; in_err = 0; in_idle = 0; cnt_clr = 0;
  endtask

  task automatic chunk(input logic [7:0] d, input bit dok);
    step(1, d, dok, 0, 0, rdy_now, 0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 1, 0, 0, rdy_now, 0);
  endtask

  task automatic clear_all();
    step(0, 8'h00, 1, 0, 0, 1, 1);
    step(0, 8'h00, 1, 0, 0, 1, 0);
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    for (int i = NCHUNK - 1; i >= 0; i--) chunk(w[i*DSIZE +: DSIZE], 1);
  endtask

  task automatic test_reset();
    _rst = 0; in_d = 0; in_st = 0; in_dok = 1; in_err = 0; in_idle = 0;
    evt_ready = 1; cnt_clr = 0; rdy_now = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", evt_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({cnt_par, cnt_trunc, cnt_ovf} !== 48'h0) begin n_fail++; $display("FAIL reset_cnt: got %h %h %h want 0", cnt_par, cnt_trunc, cnt_ovf); end
    @(negedge clk); _rst = 1;
  endtask

  task automatic test_basic();
    rdy_now = 1;
    clear_all();
    chunk(8'h12, 1); quiet(3);
    chunk(8'h34, 1); quiet(3);
    chunk(8'h56, 1); quiet(3);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", evt_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    chunk(8'h78, 1);
    n_cmp++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", evt_valid); end
    n_cmp++; if (evt_data !== 32'h12345678) begin n_fail++; $display("FAIL basic_data: got %h want 12345678", evt_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", busy); end
    quiet(1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", evt_valid); end
  endtask

  task automatic test_parity();
    rdy_now = 1;
    clear_all();
    chunk(8'hA0, 1); chunk(8'hA1, 0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL par_busy: got %b want 1", busy); end
    chunk(8'hA2, 1); chunk(8'hA3, 1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL par_valid: got %b want 0", evt_valid); end
    n_cmp++; if (cnt_par !== 16'd1) begin n_fail++; $display("FAIL par_cnt: got %0d want 1", cnt_par); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL par_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [WW-1:0] w;
    rdy_now = 1;
    clear_all();
    chunk(8'h01, 1); chunk(8'h02, 1);
    quiet(TO_MAX - 1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_before: got %b want 1", busy); end
    quiet(1);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
    n_cmp++; if (cnt_trunc !== 16'd1) begin n_fail++; $display("FAIL to_cnt: got %0d want 1", cnt_trunc); end
    w = 32'hCAFE0123;
    send_word(w);
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== w) begin n_fail++; $display("FAIL to_next_word: got %b/%h want 1/%h", evt_valid, evt_data, w); end
    quiet(1);
    // A chunk landing on the last allowed gap cycle continues the frame.
    chunk(8'h11, 1); quiet(TO_MAX - 1); chunk(8'h22, 1);
    chunk(8'h33, 1); chunk(8'h44, 1);
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 32'h11223344) begin n_fail++; $display("FAIL to_edge: got %b/%h want 1/11223344", evt_valid, evt_data); end
    n_cmp++; if (cnt_trunc !== 16'd1) begin n_fail++; $display("FAIL to_edge_cnt: got %0d want 1", cnt_trunc); end
    quiet(1);
  endtask

  task automatic test_abort();
    rdy_now = 1;
    clear_all();
    chunk(8'h10, 1); chunk(8'h20, 1); chunk(8'h30, 1);
    step(0, 8'h00, 1, 0, 1, 1, 0);
    n_cmp++; if (cnt_trunc !== 16'd1) begin n_fail++; $display("FAIL idle_cnt: got %0d want 1", cnt_trunc); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    chunk(8'h40, 1); chunk(8'h50, 1);
    step(1, 8'h60, 1, 1, 0, 1, 0);
    n_cmp++; if (cnt_trunc !== 16'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL err_abort: got %0d/%b want 2/0", cnt_trunc, busy); end
    step(1, 8'h70, 1, 1, 0, 1, 0);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_idle_chunk: got %b want 0", busy); end
    step(0, 8'h00, 1, 1, 0, 1, 0);
    step(0, 8'h00, 1, 0, 1, 1, 0);
    n_cmp++; if (cnt_trunc !== 16'd2) begin n_fail++; $display("FAIL idle_ignore: got %0d want 2", cnt_trunc); end
    send_word(32'h0BADF00D);
    n_cmp++; if (evt_valid !== 1'b1 || evt_data !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_next: got %b/%h want 1/0badf00d", evt_valid, evt_data); end
    quiet(1);
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w1, w2, w3, w4, w5;
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom; w5 = $urandom;
    rdy_now = 1;
    clear_all();
    rdy_now = 0;
    send_word(w1); send_word(w2); send_word(w3);
    n_cmp++; if (cnt_ovf !== 16'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 1", cnt_ovf); end
    n_cmp++; if (evt_data !== w1 || evt_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_head1: got %h want %h", evt_data, w1); end
    quiet(2);
    n_cmp++; if (evt_data !== w1) begin n_fail++; $display("FAIL fifo_stable: got %h want %h", evt_data, w1); end
    rdy_now = 1; quiet(1); rdy_now = 0;
    n_cmp++; if (evt_data !== w2 || evt_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_head2: got %h want %h", evt_data, w2); end
    send_word(w4);
    for (int i = NCHUNK - 1; i > 0; i--) chunk(w5[i*DSIZE +: DSIZE], 1);
    rdy_now = 1; chunk(w5[DSIZE-1:0], 1); rdy_now = 0;
    n_cmp++; if (cnt_ovf !== 16'd1) begin n_fail++; $display("FAIL full_pop_push: got %0d want 1", cnt_ovf); end
    n_cmp++; if (evt_data !== w4) begin n_fail++; $display("FAIL fifo_head4: got %h want %h", evt_data, w4); end
    rdy_now = 1; quiet(1);
    n_cmp++; if (evt_data !== w5 || evt_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_head5: got %h want %h", evt_data, w5); end
    quiet(1);
    n_cmp++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_drain: got %b want 0", evt_valid); end
  endtask

  task automatic test_saturation();
    rdy_now = 1;
    clear_all();
    @(negedge clk);
    force dut.cnt_trunc_q = 16'hFFFF;
    step(0, 8'h00, 1, 0, 0, 1, 0);
    release dut.cnt_trunc_q;
    m_trunc = 65535;
    chunk(8'h01, 1);
    step(0, 8'h00, 1, 0, 1, 1, 0);
    n_cmp++; if (cnt_trunc !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", cnt_trunc); end
    chunk(8'h02, 1);
    step(0, 8'h00, 1, 0, 1, 1, 1);
    n_cmp++; if (cnt_trunc !== 16'h0000) begin n_fail++; $display("FAIL clr_wins: got %h want 0", cnt_trunc); end
  endtask

  task automatic test_reset_midword();
    rdy_now = 0;
    clear_all();
    chunk(8'hE0, 0); chunk(8'hE1, 1); chunk(8'hE2, 1); chunk(8'hE3, 1);
    send_word(32'h5A5A5A5A);
    chunk(8'h99, 1); chunk(8'h98, 1);
    n_cmp++; if (cnt_par !== 16'd1 || busy !== 1'b1 || evt_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst: got %0d/%b/%b want 1/1/1", cnt_par, busy, evt_valid); end
    #1 _rst = 0;
    #1;
    n_cmp++; if (evt_valid !== 1'b0 || evt_data !== '0) begin n_fail++; $display("FAIL rst_async_out: got %b/%h want 0/0", evt_valid, evt_data); end
    n_cmp++; if (busy !== 1'b0 || {cnt_par, cnt_trunc, cnt_ovf} !== 48'h0) begin n_fail++; $display("FAIL rst_async_cnt: got %b %h %h %h want 0", busy, cnt_par, cnt_trunc, cnt_ovf); end
    #1 _rst = 1;
    model_reset();
    rdy_now = 1;
    quiet(TO_MAX + 2);
    n_cmp++; if ({cnt_par, cnt_trunc, cnt_ovf} !== 48'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_count: got %h %h %h want 0", cnt_par, cnt_trunc, cnt_ovf); end
  endtask

  task automatic test_random();
    bit st, dok, err, idle, rdy, clr;
    logic [7:0] d;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        quiet($urandom_range(TO_MAX - 3, TO_MAX + 3));
      end
      st   = ($urandom_range(0, 99) < 55);
      dok  = ($urandom_range(0, 99) < 92);
      err  = ($urandom_range(0, 99) < 3);
      idle = ($urandom_range(0, 99) < 3);
      rdy  = ($urandom_range(0, 99) < 60);
      clr  = ($urandom_range(0, 199) == 0);
      d    = 8'($urandom);
      step(st, d, dok, err, idle, rdy, clr);
      n_cmp++; if (evt_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, evt_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        n_cmp++; if (evt_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, evt_data, m_q[0]); end
      end
      n_cmp++; if (busy !== m_frame) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_frame); end
      n_cmp++; if (cnt_par !== 16'(m_par)) begin n_fail++; $display("FAIL rnd_par c%0d: got %0d want %0d", c, cnt_par, m_par); end
      n_cmp++; if (cnt_trunc !== 16'(m_trunc)) begin n_fail++; $display("FAIL rnd_trunc c%0d: got %0d want %0d", c, cnt_trunc, m_trunc); end
      n_cmp++; if (cnt_ovf !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %0d want %0d", c, cnt_ovf, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hssaer_evt_asm.md
HSSAER_EVT_ASM -- requirements
Module: hssaer_evt_asm

Interface
REQ-001 SHALL have parameter DSIZE, 8, chunk width delivered by the HSSAER character decoder.
REQ-002 SHALL have parameter NCHUNK, 4, chunks per event word; legal range 2..8.
REQ-003 SHALL have parameter TO_MAX, 64, maximum inter-chunk gap in clk cycles; legal range 2..255.
REQ-004 SHALL have port clk, in, 1, clock.
REQ-005 SHALL have port _rst, in, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port in_d, in, DSIZE, decoded chunk data.
REQ-007 SHALL have port in_st, in, 1, one-cycle strobe marking in_d valid.
REQ-008 SHALL have port in_dok, in, 1, parity-good qualifier, sampled with in_st.
REQ-009 SHALL have port in_err, in, 1, decoder symbol error pulse.
REQ-010 SHALL have port in_idle, in, 1, idle-character pulse, the frame boundary.
REQ-011 SHALL have port evt_data, out, DSIZE*NCHUNK, assembled event word.
REQ-012 SHALL have port evt_valid, out, 1, evt_data valid.
REQ-013 SHALL have port evt_ready, in, 1, consumer accepts the word when evt_valid&&evt_ready.
REQ-014 SHALL have port cnt_clr, in, 1, synchronous clear of all statistics counters.
REQ-015 SHALL have ports cnt_par, cnt_trunc and cnt_ovf, out, 16 each: parity-bad, truncated and overflow-dropped word counts.
REQ-016 SHALL have port busy, out, 1, high while the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT and DROP.
REQ-018 IDLE: in_st SHALL load chunk 0 (most significant), set index=1, clear timer, and go to COLLECT; if in_dok=0, go to DROP and set the bad flag.
REQ-019 COLLECT: each in_st SHALL append in_d below the previous chunks and increment index; in_dok=0 SHALL go to DROP.
REQ-020 The chunk completing index=NCHUNK with all dok=1 SHALL push the word to the output FIFO and return to IDLE.
REQ-021 DROP: chunks SHALL be consumed without storing; on the NCHUNK-th chunk, cnt_par SHALL increment by 1 and the FSM SHALL return to IDLE.
REQ-022 The timer SHALL count cycles without in_st in COLLECT/DROP; on reaching TO_MAX the partial word SHALL be discarded, cnt_trunc SHALL increment and the FSM SHALL return to IDLE.
REQ-023 in_err or in_idle in COLLECT/DROP SHALL abort the partial word the same way as a timeout, with cnt_trunc+1.
REQ-024 in_err or in_idle in IDLE SHALL be ignored.
REQ-025 Priority in one cycle SHALL be in_err > in_idle > in_st; a chunk arriving with in_err is discarded.
REQ-026 A chunk arriving on the same cycle the timer reaches TO_MAX SHALL be accepted and SHALL reset the timer.
REQ-027 Latency SHALL be fixed: evt_valid rises the cycle after the completing in_st when the FIFO was empty.
REQ-028 The output FIFO SHALL hold 2 entries in first-in first-out order; evt_data SHALL be stable while evt_valid&&!evt_ready.
REQ-029 A push when the FIFO is full and not popped the same cycle SHALL drop the new word and increment cnt_ovf; a push on a full FIFO with a simultaneous pop SHALL be accepted.
REQ-030 Counters SHALL saturate at 0xFFFF; cnt_clr SHALL win over an increment in the same cycle.

Reset
REQ-031 _rst low SHALL force IDLE, index=0, timer=0, FIFO empty, evt_valid=0, evt_data=0, all counters=0 and busy=0, asynchronously.
REQ-032 Reset asserted mid-word SHALL discard the partial word and SHALL NOT increment any counter.

Structure
REQ-033 Package hssaer_pkg SHALL hold the FSM state type, the default DSIZE/NCHUNK/TO_MAX values and the counter width (16).
REQ-034 The 2-entry FIFO SHALL be the sub-module hssaer_fifo2, with push/pop/full/empty and an async active-low reset.

Verification
REQ-035 NCHUNK=4: chunks 0x12,0x34,0x56,0x78 with dok=1, gaps of 3 cycles -> evt_data=0x12345678, evt_valid 1 cycle after the 4th strobe.
REQ-036 Second chunk with dok=0, remaining chunks good -> no output word; cnt_par=1; FSM back in IDLE after the 4th chunk.
REQ-037 Two chunks, then no strobe for TO_MAX cycles -> cnt_trunc=1, busy=0; the next 4 good chunks yield a correct word.
REQ-038 in_idle after 3 chunks -> cnt_trunc=1; in_err simultaneous with a strobe -> the chunk is discarded.
REQ-039 evt_ready=0 and 3 complete words -> words 1 and 2 retained in order; cnt_ovf=1; with evt_ready=1 on a full FIFO during a push -> no drop.
REQ-040 Counter forced to 0xFFFF plus another error -> it holds 0xFFFF; cnt_clr together with an increment -> 0; _rst low mid-word -> all outputs 0.
